// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with an optional iterative RV32M multiply/divide unit.
// The MDU is built only when ALU_CTRL_MDU_EN is defined.
module alu_ctrl_mdu #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ALUop,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [6:0]        op,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] ALUctrl,
  output logic              is_mdu_o,
  output logic              stall_o,
  output logic              mdu_valid_o,
  output logic [WIDTH-1:0]  mdu_result_o
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [3:0] code;
  logic       unused_op;

  // Base RV32I ALU decode; M-ops also fall through this table
  always_comb begin
    code = ALU_ADD;
    case (ALUop)
      2'b00: code = ALU_ADD;
      2'b01: code = ALU_SUB;
      2'b11: code = ALU_PASSB;
      default: begin
        case (funct3)
          3'b000:  code = (op[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLTU;
          3'b100:  code = ALU_XOR;
          3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
    endcase
  end

  assign ALUctrl   = CTRL_W'(code);
  assign unused_op = ^{op[6], op[4:0]};

`ifdef ALU_CTRL_MDU_EN

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [WIDTH-1:0]   opnd, opnd_nx;
  logic [WIDTH-1:0]   hi, hi_nx;
  logic [WIDTH-1:0]   lo, lo_nx;
  logic [2:0]         fn, fn_nx;
  logic               neg_q, neg_q_nx;
  logic               neg_r, neg_r_nx;
  logic               valid_nx;
  logic [WIDTH-1:0]   result_nx;

  logic               a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_t, div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fin;

  assign is_mdu_o = (ALUop == 2'b10) & op[5] & (funct7 == 7'b0000001);
  assign stall_o  = ((state == IDLE) & start_i & is_mdu_o & ~flush_i) | (state == CALC);

  // Operand signedness, magnitudes and divide special cases for the incoming op
  always_comb begin
    a_neg    = src_a[WIDTH-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                 (funct3 == 3'b100) | (funct3 == 3'b110));
    b_neg    = src_b[WIDTH-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                                 (funct3 == 3'b110));
    mag_a    = a_neg ? -src_a : src_a;
    mag_b    = b_neg ? -src_b : src_b;
    is_div   = funct3[2];
    div_zero = is_div & (src_b == '0);
    div_ovf  = is_div & ~funct3[0] & (src_a == MIN_VAL) & (src_b == '1);
  end

  // One shift-add or restoring-subtract step, plus sign-corrected final result
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_t    = {hi, lo[WIDTH-1]};
    div_diff = div_t - {1'b0, opnd};
    if (fn[2]) begin
      step_hi = div_diff[WIDTH] ? div_t[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
    prod_s = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    case (fn)
      3'b000:         fin = prod_s[WIDTH-1:0];
      3'b100, 3'b101: fin = neg_q ? -step_lo : step_lo;
      3'b110, 3'b111: fin = neg_r ? -step_hi : step_hi;
      default:        fin = prod_s[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    opnd_nx   = opnd;
    hi_nx     = hi;
    lo_nx     = lo;
    fn_nx     = fn;
    neg_q_nx  = neg_q;
    neg_r_nx  = neg_r;
    valid_nx  = 1'b0;
    result_nx = mdu_result_o;
    case (state)
      IDLE: begin
        if (start_i & is_mdu_o) begin
          fn_nx = funct3;
          if (div_zero) begin
            result_nx = funct3[1] ? src_a : '1;
            valid_nx  = 1'b1;
            state_nx  = DONE;
          end else if (div_ovf) begin
            result_nx = funct3[1] ? '0 : src_a;
            valid_nx  = 1'b1;
            state_nx  = DONE;
          end else begin
            cnt_nx   = CNT_W'(WIDTH);
            neg_q_nx = a_neg ^ b_neg;
            neg_r_nx = a_neg;
            hi_nx    = '0;
            opnd_nx  = is_div ? mag_b : mag_a;
            lo_nx    = is_div ? mag_a : mag_b;
            state_nx = CALC;
          end
        end
      end
      CALC: begin
        hi_nx  = step_hi;
        lo_nx  = step_lo;
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          result_nx = fin;
          valid_nx  = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Flush wins over everything, including a start in the same cycle
    if (flush_i) begin
      state_nx  = IDLE;
      cnt_nx    = '0;
      valid_nx  = 1'b0;
      result_nx = mdu_result_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      opnd         <= '0;
      hi           <= '0;
      lo           <= '0;
      fn           <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      mdu_valid_o  <= 1'b0;
      mdu_result_o <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      opnd         <= opnd_nx;
      hi           <= hi_nx;
      lo           <= lo_nx;
      fn           <= fn_nx;
      neg_q        <= neg_q_nx;
      neg_r        <= neg_r_nx;
      mdu_valid_o  <= valid_nx;
      mdu_result_o <= result_nx;
    end
  end

`else

  logic unused_mdu;

  assign is_mdu_o     = 1'b0;
  assign stall_o      = 1'b0;
  assign mdu_valid_o  = 1'b0;
  assign mdu_result_o = '0;
  assign unused_mdu   = ^{clk, rst_n, start_i, flush_i, src_a, src_b,
                          funct7[6], funct7[4:0]};

`endif

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench for alu_ctrl_mdu: decoder sweep, M-op results/latency, flush and reset.
module tb_alu_ctrl_mdu;

  localparam int W = 32;
`ifdef ALU_CTRL_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   ALUop;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [6:0]   op;
  logic         start_i;
  logic         flush_i;
  logic [W-1:0] src_a, src_b;
  logic [3:0]   ALUctrl;
  logic         is_mdu_o, stall_o, mdu_valid_o;
  logic [W-1:0] mdu_result_o;

  alu_ctrl_mdu #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ALUop(ALUop), .funct3(funct3), .funct7(funct7),
    .op(op), .start_i(start_i), .flush_i(flush_i), .src_a(src_a), .src_b(src_b),
    .ALUctrl(ALUctrl), .is_mdu_o(is_mdu_o), .stall_o(stall_o),
    .mdu_valid_o(mdu_valid_o), .mdu_result_o(mdu_result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] val;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every result pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_o) stall_cnt++;
      if (mdu_valid_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got result %h expected no pulse", mdu_result_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(e.name, mdu_result_o, e.val);
          check({e.name, "_latency"}, W'(cyc - e.t0), W'(e.lat));
        end
      end
    end
  end

  function automatic logic [3:0] dec_model(input logic [1:0] aop, input logic [2:0] f3,
                                           input logic f7b5, input logic o5);
    case (aop)
      2'd0: return 4'd0;
      2'd1: return 4'd1;
      2'd3: return 4'd10;
      default:
        case (f3)
          3'd0: return (o5 && f7b5) ? 4'd1 : 4'd0;
          3'd1: return 4'd7;
          3'd2: return 4'd5;
          3'd3: return 4'd6;
          3'd4: return 4'd4;
          3'd5: return f7b5 ? 4'd9 : 4'd8;
          3'd6: return 4'd3;
          default: return 4'd2;
        endcase
    endcase
  endfunction

  task automatic drive_m(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUop   = 2'b10;
    op      = 7'b0110011;
    funct7  = 7'b0000001;
    funct3  = f3;
    src_a   = a;
    src_b   = b;
    start_i = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
    #1;
  endtask

  // Called at posedge+1; start is held for exactly one cycle
  task automatic run_op(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int s0;
    exp_t e;
    s0 = stall_cnt;
    drive_m(f3, a, b);
    e.name = name; e.val = exp; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_drain(name);
    check({name, "_stalls"}, W'(stall_cnt - s0), W'(lat));
  endtask

  initial begin
    rst_n = 1'b0; ALUop = '0; funct3 = '0; funct7 = '0; op = '0;
    start_i = 1'b0; flush_i = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", W'(stall_o), '0);
    check("rst_valid", W'(mdu_valid_o), '0);
    check("rst_result", mdu_result_o, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decoder sweep with start low
    for (int aop = 0; aop < 4; aop++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int f = 0; f < 2; f++)
          for (int o = 0; o < 2; o++) begin
            ALUop  = 2'(aop);
            funct3 = 3'(f3);
            funct7 = (f != 0) ? 7'b0100000 : 7'b0000000;
            op     = (o != 0) ? 7'b0110011 : 7'b0010011;
            #1;
            check($sformatf("dec_%0d_%0d_%0d_%0d", aop, f3, f, o), W'(ALUctrl),
                  W'(dec_model(2'(aop), 3'(f3), f != 0, o != 0)));
            check("dec_stall", W'(stall_o), '0);
          end
    ALUop = 2'b10; funct3 = 3'b000; funct7 = 7'b0100000; op = 7'b0110011; #1;
    check("dec_sub_r", W'(ALUctrl), W'(1));
    op = 7'b0010011; #1;
    check("dec_addi_f7", W'(ALUctrl), W'(0));
    ALUop = 2'b10; funct3 = 3'b000; funct7 = 7'b0000001; op = 7'b0110011; #1;
    check("mul_aluctrl", W'(ALUctrl), W'(0));
    check("mul_is_mdu", W'(is_mdu_o), W'(MDU));
    @(posedge clk); #1;

`ifdef ALU_CTRL_MDU_EN
    run_op("mulh_min_m1",  3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, W+1);
    run_op("mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, W+1);
    run_op("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, W+1);
    run_op("mulhsu_m1_2",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, W+1);
    run_op("mulh_pos",     3'b001, 32'h12345678, 32'h10,       32'h00000001, W+1);
    run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, W+1);
    run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, W+1);
    run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       W+1);
    run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        W+1);
    run_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, W+1);
    run_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        W+1);
    run_op("divu_min_max", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        W+1);
    run_op("div_5_0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_5_0",      3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("divu_5_0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("remu_9_4",     3'b111, 32'd9,        32'd4,        32'd1,        W+1);

    // Flush in CALC cycle 10: no pulse, back to IDLE
    drive_m(3'b000, 32'd3, 32'd5);
    @(posedge clk); #1;
    start_i = 1'b0;
    check("flush_calc_stall", W'(stall_o), W'(1));
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_stall_low", W'(stall_o), '0);
    check("flush_no_valid", W'(mdu_valid_o), '0);
    repeat (W + 5) @(posedge clk);
    #1;
    run_op("after_flush", 3'b000, 32'd6, 32'd7, 32'd42, W+1);

    // Asynchronous reset mid-CALC clears everything
    drive_m(3'b011, 32'hFFFFFFFF, 32'h2);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_stall", W'(stall_o), '0);
    check("arst_valid", W'(mdu_valid_o), '0);
    check("arst_result", mdu_result_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (W + 5) @(posedge clk);
    #1;
    run_op("after_reset", 3'b101, 32'd50, 32'd5, 32'd10, W+1);
`else
    // Without the MDU an M instruction never stalls and never produces a result
    drive_m(3'b000, 32'd7, 32'hFFFFFFFD);
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("nomdu_stall_%0d", i), W'(stall_o), '0);
      check($sformatf("nomdu_aluctrl_%0d", i), W'(ALUctrl), '0);
      check($sformatf("nomdu_valid_%0d", i), W'(mdu_valid_o), '0);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    check("nomdu_result", mdu_result_o, '0);
`endif

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_results: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
